// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port indices, route codes and
// helpers that pull destination coordinates out of a flit.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;

  localparam int unsigned P_LOCAL = 0;
  localparam int unsigned P_UP    = 1;
  localparam int unsigned P_DOWN  = 2;
  localparam int unsigned P_LEFT  = 3;
  localparam int unsigned P_RIGHT = 4;

  // Widest flit the extract helpers accept; narrower flits are zero-extended.
  localparam int unsigned MAX_FLIT_W = 256;

  // Route codes 0..4 equal the output port index they select.
  typedef enum logic [2:0] {
    R_LOCAL = 3'd0,
    R_UP    = 3'd1,
    R_DOWN  = 3'd2,
    R_LEFT  = 3'd3,
    R_RIGHT = 3'd4,
    R_DROP  = 3'd5
  } route_t;

  function automatic int unsigned coord_field(input logic [MAX_FLIT_W-1:0] flit,
                                              input int unsigned lsb,
                                              input int unsigned coord_w);
    logic [63:0] mask;
    mask = (64'd1 << coord_w) - 64'd1;
    return 32'(flit >> lsb) & 32'(mask);
  endfunction

  // dst_x occupies the top coord_w bits of the flit.
  function automatic int unsigned dst_x_of(input logic [MAX_FLIT_W-1:0] flit,
                                           input int unsigned data_w,
                                           input int unsigned coord_w);
    return coord_field(flit, data_w - coord_w, coord_w);
  endfunction

  // dst_y sits directly below dst_x.
  function automatic int unsigned dst_y_of(input logic [MAX_FLIT_W-1:0] flit,
                                           input int unsigned data_w,
                                           input int unsigned coord_w);
    return coord_field(flit, data_w - 2 * coord_w, coord_w);
  endfunction

  // Dimension-ordered XY routing; destinations outside the mesh are dropped.
  function automatic route_t route_of(input int unsigned dx, input int unsigned dy,
                                      input int unsigned xl, input int unsigned yl,
                                      input int unsigned mx, input int unsigned my);
    if (dx >= mx || dy >= my) return R_DROP;
    if (dx > xl) return R_RIGHT;
    if (dx < xl) return R_LEFT;
    if (dy > yl) return R_DOWN;
    if (dy < yl) return R_UP;
    return R_LOCAL;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous input FIFO for one router port. Head data is presented
// combinationally from storage, so a flit pushed on one edge is at the head
// in the following cycle. Push is refused when full (no bypass).
module router_fifo #(
  parameter int unsigned DATA_W = 39,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Qualify push/pop against full/empty and advance the pointers.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + (AW + 1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(do_pop);
  end

  // Pointer state; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mesh_router_sync.sv
// Clocked 5-port XY mesh router node. Port order: 0 local, 1 up, 2 down,
// 3 left, 4 right. Each input has a FIFO; each output has a round-robin
// arbiter and a valid/ready output register. Off-mesh heads are dropped.
// Optional per-output forwarded-flit counters: define NOC_ROUTER_STATS_EN.
module mesh_router_sync
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W     = 39,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned MESH_X     = 3,
  parameter int unsigned MESH_Y     = 5,
  parameter int unsigned X_LOCAL    = 0,
  parameter int unsigned Y_LOCAL    = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS-1:0]          drop_pulse,
  output logic [NUM_PORTS*32-1:0]       stat_fwd_cnt
);

  logic [NUM_PORTS-1:0]  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0]     head_data  [NUM_PORTS];
  logic [MAX_FLIT_W-1:0] head_wide  [NUM_PORTS];
  route_t                head_route [NUM_PORTS];

  // req[o][p]: head of input p wants output o. grant[o][p] likewise.
  logic [NUM_PORTS-1:0]  req   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  grant [NUM_PORTS];
  logic [NUM_PORTS-1:0]  drop;

  logic [2:0]            rr_q       [NUM_PORTS];
  logic [2:0]            rr_d       [NUM_PORTS];
  logic [NUM_PORTS-1:0]  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q [NUM_PORTS];
  logic [DATA_W-1:0]     out_data_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]  drop_pulse_q;

  assign in_ready   = ~fifo_full;
  assign fifo_push  = in_valid & ~fifo_full;
  assign out_valid  = out_valid_q;
  assign drop_pulse = drop_pulse_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    router_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (fifo_push[p]),
      .wdata_i (in_data[p*DATA_W +: DATA_W]),
      .pop_i   (fifo_pop[p]),
      .rdata_o (head_data[p]),
      .full_o  (fifo_full[p]),
      .empty_o (fifo_empty[p])
    );

    assign head_wide[p] = {{(MAX_FLIT_W - DATA_W){1'b0}}, head_data[p]};
    assign out_data[p*DATA_W +: DATA_W] = out_data_q[p];
  end

  // Route every FIFO head and turn routes into per-output request vectors.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      head_route[p] = route_of(dst_x_of(head_wide[p], DATA_W, COORD_W),
                               dst_y_of(head_wide[p], DATA_W, COORD_W),
                               X_LOCAL, Y_LOCAL, MESH_X, MESH_Y);
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        req[o][p] = !fifo_empty[p] && (head_route[p] == route_t'(3'(o)));
      end
    end
  end

  // Round-robin grant per loadable output, output register load, and pops.
  always_comb begin
    int unsigned idx;
    int unsigned gidx;
    logic        found;
    out_valid_d = out_valid_q;
    fifo_pop    = '0;
    drop        = '0;
    idx         = 0;
    gidx        = 0;
    found       = 1'b0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      rr_d[o]       = rr_q[o];
      grant[o]      = '0;
      out_data_d[o] = out_data_q[o];
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      drop[p] = !fifo_empty[p] && (head_route[p] == R_DROP);
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (!out_valid_q[o] || out_ready[o]) begin
        out_valid_d[o] = 1'b0;
        found          = 1'b0;
        gidx           = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          idx = 32'(rr_q[o]) + i;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          if (!found && req[o][idx]) begin
            found = 1'b1;
            gidx  = idx;
          end
        end
        if (found) begin
          grant[o][gidx] = 1'b1;
          rr_d[o]        = (gidx == NUM_PORTS - 1) ? 3'd0 : 3'(gidx + 1);
          out_valid_d[o] = 1'b1;
          out_data_d[o]  = head_data[gidx];
        end
      end
    end
    fifo_pop = drop;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      fifo_pop = fifo_pop | grant[o];
    end
  end

  // Output registers, arbiter pointers and drop pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= '0;
      drop_pulse_q <= '0;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= '0;
        rr_q[o]       <= '0;
      end
    end else begin
      out_valid_q  <= out_valid_d;
      drop_pulse_q <= drop;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        out_data_q[o] <= out_data_d[o];
        rr_q[o]       <= rr_d[o];
      end
    end
  end

`ifdef NOC_ROUTER_STATS_EN
  logic [31:0] stat_q [NUM_PORTS];

  // Count completed output handshakes, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) stat_q[o] <= '0;
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (out_valid_q[o] && out_ready[o] && (stat_q[o] != 32'hFFFF_FFFF)) begin
          stat_q[o] <= stat_q[o] + 32'd1;
        end
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_stat
    assign stat_fwd_cnt[o*32 +: 32] = stat_q[o];
  end
`else
  assign stat_fwd_cnt = '0;
`endif

endmodule

// File: tb/tb_mesh_router_sync.sv
// Scoreboard bench for mesh_router_sync at node (1,1) of a 3x5 mesh.
module tb_mesh_router_sync;

  localparam int unsigned DW = 39;
  localparam int unsigned NP = 5;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;  // exact expected cycle, or -1 for any
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    in_valid, in_ready, out_valid, out_ready, drop_pulse;
  logic [NP*DW-1:0] in_data, out_data;
  logic [NP*32-1:0] stat_fwd_cnt;

  exp_t sb_q [NP][$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   drop_cnt [NP];

  mesh_router_sync #(
    .X_LOCAL (1),
    .Y_LOCAL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .drop_pulse   (drop_pulse),
    .stat_fwd_cnt (stat_fwd_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int x, input int y, input int pl);
    return {4'(x), 4'(y), 31'(pl)};
  endfunction

  task automatic expect_out(input int o, input logic [DW-1:0] d, input int cyc);
    exp_t e;
    e.data = d;
    e.cyc  = cyc;
    sb_q[o].push_back(e);
  endtask

  function automatic int pending();
    int n = 0;
    for (int o = 0; o < NP; o++) n += sb_q[o].size();
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (n < 100 && pending() != 0) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, 64'(pending()), 64'd0);
  endtask

  task automatic clear_sb();
    for (int o = 0; o < NP; o++) begin
      sb_q[o].delete();
      drop_cnt[o] = 0;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    tick();
    tick();
    rst = 1'b0;
    clear_sb();
  endtask

  // Compare each completed output handshake against the scoreboard; count drops.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int o = 0; o < NP; o++) begin
        if (drop_pulse[o] === 1'b1) drop_cnt[o]++;
        if (out_valid[o] === 1'b1 && out_ready[o] === 1'b1) begin
          if (sb_q[o].size() == 0) begin
            check_eq($sformatf("unexpected_out%0d_q_size", o), 64'(sb_q[o].size()), 64'd1);
          end else begin
            exp_t e;
            e = sb_q[o].pop_front();
            check_eq($sformatf("out%0d_data", o), 64'(out_data[o*DW +: DW]), 64'(e.data));
            if (e.cyc >= 0) check_eq($sformatf("out%0d_cycle", o), 64'(cycle), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    int acc;
    logic rdy;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    clear_sb();
    tick();
    tick();
    // Reset state
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data[DW-1:0] | out_data[4*DW +: DW]), 64'd0);
    check_eq("rst_drop", 64'(drop_pulse), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'h1f);
    check_eq("rst_stat", 64'(stat_fwd_cnt[63:0]), 64'd0);
    rst = 1'b0;
    tick();

    // Local inject to the east neighbour, 2-cycle latency
    in_data[0 +: DW] = mk(2, 1, 'h123);
    in_valid = 5'b00001;
    expect_out(4, mk(2, 1, 'h123), cycle + 2);
    tick();
    in_valid = '0;
    wait_drain("local_east");

    // Three simultaneous flits for the local output, then a four-way repeat
    do_reset();
    for (int p = 1; p <= 3; p++) in_data[p*DW +: DW] = mk(1, 1, 'h200 + p);
    in_valid = 5'b01110;
    for (int p = 1; p <= 3; p++) expect_out(0, mk(1, 1, 'h200 + p), cycle + 1 + p);
    tick();
    in_valid = '0;
    wait_drain("rr_burst1");
    for (int p = 1; p <= 4; p++) in_data[p*DW +: DW] = mk(1, 1, 'h300 + p);
    in_valid = 5'b11110;
    expect_out(0, mk(1, 1, 'h304), cycle + 2);
    for (int p = 1; p <= 3; p++) expect_out(0, mk(1, 1, 'h300 + p), cycle + 2 + p);
    tick();
    in_valid = '0;
    wait_drain("rr_burst2");

    // Backpressure on the left output
    do_reset();
    out_ready[3] = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      in_data[0 +: DW] = mk(0, 1, 'h400 + acc);
      in_valid[0] = 1'b1;
      @(negedge clk);
      rdy = in_ready[0];
      tick();
      if (rdy) begin
        expect_out(3, mk(0, 1, 'h400 + acc), -1);
        acc++;
      end
    end
    in_valid = '0;
    @(negedge clk);
    check_eq("bp_accepted", 64'(acc), 64'd5);
    check_eq("bp_in_ready0", 64'(in_ready[0]), 64'd0);
    check_eq("bp_out_valid3", 64'(out_valid[3]), 64'd1);
    tick();
    out_ready[3] = 1'b1;
    wait_drain("bp_release");
    check_eq("bp_in_ready_after", 64'(in_ready), 64'h1f);

    // Off-mesh destinations are dropped
    do_reset();
    in_valid[4] = 1'b1;
    in_data[4*DW +: DW] = mk(3, 1, 'h600);
    tick();
    in_data[4*DW +: DW] = mk(1, 5, 'h601);
    tick();
    in_valid = '0;
    for (int k = 0; k < 5; k++) tick();
    check_eq("drop_cnt4", 64'(drop_cnt[4]), 64'd2);
    check_eq("drop_cnt_other", 64'(drop_cnt[0] + drop_cnt[1] + drop_cnt[2] + drop_cnt[3]), 64'd0);
    check_eq("drop_no_valid", 64'(out_valid), 64'd0);

    // Reset while flits are buffered
    do_reset();
    out_ready[3] = 1'b0;
    in_valid[0]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[0 +: DW] = mk(0, 1, 'h500 + k);
      tick();
    end
    in_valid = '0;
    tick();
    check_eq("pre_rst_out_valid3", 64'(out_valid[3]), 64'd1);
    rst = 1'b1;
    tick();
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'h1f);
    check_eq("midrst_out_data3", 64'(out_data[3*DW +: DW]), 64'd0);
    rst = 1'b0;
    clear_sb();
    out_ready = '1;
    for (int k = 0; k < 4; k++) tick();
    in_data[0 +: DW] = mk(0, 1, 'h5aa);
    in_valid[0] = 1'b1;
    expect_out(3, mk(0, 1, 'h5aa), cycle + 2);
    tick();
    in_valid = '0;
    wait_drain("post_rst");

    // Ten flits to the down output
    do_reset();
    in_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data[0 +: DW] = mk(1, 2, 'h700 + k);
      expect_out(2, mk(1, 2, 'h700 + k), cycle + 2);
      tick();
    end
    in_valid = '0;
    wait_drain("down10");
    tick();
`ifdef NOC_ROUTER_STATS_EN
    for (int o = 0; o < NP; o++) begin
      check_eq($sformatf("stat%0d", o), 64'(stat_fwd_cnt[o*32 +: 32]), (o == 2) ? 64'd10 : 64'd0);
    end
`else
    check_eq("stat_tied_low", 64'(stat_fwd_cnt[127:64]), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cycle=%0d required=finish", cycle);
    $fatal(1);
  end

endmodule
